// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding, default
// configuration and the settle-counter width rule.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          DEF_WIDTH    = 4;
  localparam int          DEF_N        = 1 << DEF_WIDTH;
  localparam logic [15:0] DEF_EXPECTED = 16'h0AC5;

  // A zero settle time still needs a 1-bit counter register.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner.sv
// Walks x_out through every input code, samples z_in once per code after the
// settle time, and compares the captured truth vector against EXPECTED.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int                      WIDTH    = DEF_WIDTH,
  parameter int                      SETTLE   = 1,
  parameter logic [(1<<WIDTH)-1:0]   EXPECTED = DEF_EXPECTED
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [WIDTH-1:0]        x_out,
  input  logic                    z_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<WIDTH)-1:0]   truth,
  output logic                    match,
  output logic [WIDTH-1:0]        mismatch_idx
);

  localparam int               N        = 1 << WIDTH;
  localparam int               CW       = cnt_width(SETTLE);
  localparam logic [CW-1:0]    SETTLE_C = CW'(SETTLE);
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       truth_q, truth_d, truth_smp;
  logic               match_q, match_d;
  logic [WIDTH-1:0]   midx_q, midx_d;

  // Lowest set bit of the difference vector; 0 when there is no difference.
  function automatic logic [WIDTH-1:0] first_diff(input logic [N-1:0] v);
    first_diff = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) first_diff = i[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    truth_d   = truth_q;
    match_d   = match_q;
    midx_d    = midx_q;
    truth_smp = truth_q;
    truth_smp[idx_q] = z_in;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HOLD;
          idx_d   = '0;
          cnt_d   = SETTLE_C;
          truth_d = '0;
          match_d = 1'b0;
          midx_d  = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          truth_d = truth_smp;
          if (idx_q != LAST) begin
            idx_d = idx_q + 1'b1;
            cnt_d = SETTLE_C;
          end else begin
            // Verdict uses the vector including the bit sampled on this edge.
            state_d = ST_DONE;
            idx_d   = '0;
            match_d = (truth_smp == EXPECTED);
            midx_d  = first_diff(truth_smp ^ EXPECTED);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      match_q <= 1'b0;
      midx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      match_q <= match_d;
      midx_q  <= midx_d;
    end
  end

  assign x_out        = idx_q;
  assign busy         = (state_q == ST_HOLD);
  assign done         = (state_q == ST_DONE);
  assign truth        = truth_q;
  assign match        = match_q;
  assign mismatch_idx = midx_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE = 1, 0, 3) driven by a
// behavioural boolean block with selectable faults, scored against a queue.
module tb_truth_table_scanner;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] gold_v = 16'h0AC5;
  int          fault  = 0;   // 0 golden, 1 output stuck 0, 2 inverted at x=9
  logic        glitch3 = 1'b0;

  logic        start1 = 1'b0, start0 = 1'b0, start3 = 1'b0;
  logic [3:0]  x1, x0, x3, mi1, mi0, mi3;
  logic        z1, z0, z3, busy1, busy0, busy3, done1, done0, done3;
  logic        m1, m0, m3;
  logic [15:0] t1, t0, t3;

  function automatic logic zmodel(input logic [3:0] x, input int f);
    case (f)
      1:       return 1'b0;
      2:       return gold_v[x] ^ (x == 4'd9);
      default: return gold_v[x];
    endcase
  endfunction

  assign z1 = zmodel(x1, fault);
  assign z0 = zmodel(x0, 0);
  assign z3 = zmodel(x3, 0) ^ glitch3;

  truth_table_scanner #(.WIDTH(4), .SETTLE(1), .EXPECTED(16'h0AC5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_out(x1), .z_in(z1), .busy(busy1),
    .done(done1), .truth(t1), .match(m1), .mismatch_idx(mi1));
  truth_table_scanner #(.WIDTH(4), .SETTLE(0), .EXPECTED(16'h0AC5)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .x_out(x0), .z_in(z0), .busy(busy0),
    .done(done0), .truth(t0), .match(m0), .mismatch_idx(mi0));
  truth_table_scanner #(.WIDTH(4), .SETTLE(3), .EXPECTED(16'h0AC5)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .x_out(x3), .z_in(z3), .busy(busy3),
    .done(done3), .truth(t3), .match(m3), .mismatch_idx(mi3));

  typedef struct {
    string       name;
    int          sel;      // settle value selects the instance
    int          fault;
    int          mode;     // 0 plain, 1 re-pulse start while busy, 2 glitch z_in
    logic [15:0] truth;
    logic        match;
    logic [3:0]  idx;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] truth;
    logic        match;
    logic [3:0]  idx;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start0 = v;
      3:       start3 = v;
      default: start1 = v;
    endcase
  endtask

  task automatic read_outs(input int sel, output logic [3:0] x, output logic b,
                           output logic d, output logic [15:0] t, output logic m,
                           output logic [3:0] mi);
    case (sel)
      0:       begin x = x0; b = busy0; d = done0; t = t0; m = m0; mi = mi0; end
      3:       begin x = x3; b = busy3; d = done3; t = t3; m = m3; mi = mi3; end
      default: begin x = x1; b = busy1; d = done1; t = t1; m = m1; mi = mi1; end
    endcase
  endtask

  task automatic run_scan(input vec_t v);
    exp_t        e;
    logic [3:0]  x, mi;
    logic        b, d, m, seen;
    logic [15:0] t;
    int          step_err, extra;
    e.truth = v.truth; e.match = v.match; e.idx = v.idx; e.lat = v.lat;
    sbq.push_back(e);
    fault = v.fault;
    step_err = 0;
    seen = 1'b0;
    @(negedge clk);
    set_start(v.sel, 1'b1);
    @(posedge clk);              // E0
    #1;
    set_start(v.sel, 1'b0);
    read_outs(v.sel, x, b, d, t, m, mi);
    if (!(b === 1'b1 && x === 4'd0 && t === 16'h0 && m === 1'b0)) step_err++;
    for (int n = 1; n <= 200; n++) begin
      if (v.mode == 1) set_start(v.sel, (n == 5 || n == 20));
      if (v.mode == 2) glitch3 = (n % 4 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      read_outs(v.sel, x, b, d, t, m, mi);
      if (d === 1'b1) begin
        e = sbq.pop_front();
        check({v.name, ".xstep"}, step_err, 0);
        check({v.name, ".latency"}, n + 1, e.lat);
        check({v.name, ".busy"}, b, 1'b0);
        check({v.name, ".x_idle"}, x, 4'd0);
        check({v.name, ".truth"}, t, e.truth);
        check({v.name, ".match"}, m, e.match);
        check({v.name, ".midx"}, mi, e.idx);
        seen = 1'b1;
        break;
      end
      if (!(b === 1'b1 && x === 4'(n / (v.sel + 1)))) step_err++;
    end
    set_start(v.sel, 1'b0);
    glitch3 = 1'b0;
    if (!seen) begin
      void'(sbq.pop_front());
      check({v.name, ".timeout"}, 0, 1);
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      read_outs(v.sel, x, b, d, t, m, mi);
      if (d === 1'b1 || b === 1'b1) extra++;
    end
    if (v.mode == 1) check({v.name, ".no_requeue"}, extra, 0);
    check({v.name, ".hold_truth"}, t, v.truth);
  endtask

  initial begin
    int          dn, first_d, second_d;
    logic [15:0] tsave;

    vecs.push_back('{"golden",   1, 0, 0, 16'h0AC5, 1'b1, 4'd0, 33});
    vecs.push_back('{"stuck0",   1, 1, 0, 16'h0000, 1'b0, 4'd0, 33});
    vecs.push_back('{"inv9",     1, 2, 0, 16'h08C5, 1'b0, 4'd9, 33});
    vecs.push_back('{"repulse",  1, 0, 1, 16'h0AC5, 1'b1, 4'd0, 33});
    vecs.push_back('{"settle0",  0, 0, 0, 16'h0AC5, 1'b1, 4'd0, 17});
    vecs.push_back('{"settle3g", 3, 0, 2, 16'h0AC5, 1'b1, 4'd0, 65});

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.x", x1, 4'd0);
    check("rst.busy", busy1, 1'b0);
    check("rst.done", done1, 1'b0);
    check("rst.truth", t1, 16'h0);
    check("rst.match", m1, 1'b0);
    check("rst.midx", mi1, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_scan(vecs[i]);

    // Asynchronous reset ten edges into a scan.
    fault = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.x", x1, 4'd0);
    check("midrst.busy", busy1, 1'b0);
    check("midrst.truth", t1, 16'h0);
    check("midrst.match", m1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_scan('{"after_rst", 1, 0, 0, 16'h0AC5, 1'b1, 4'd0, 33});

    // start held high: back-to-back scans.
    dn = 0; first_d = 0; second_d = 0; tsave = '0;
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) begin
        dn++;
        if (dn == 1) first_d = n; else second_d = n;
        tsave = t1;
        if (dn == 2) break;
      end
    end
    start1 = 1'b0;
    check("held.done_count", dn, 2);
    check("held.spacing", second_d - first_d, 34);
    check("held.truth", tsave, 16'h0AC5);
    repeat (5) @(posedge clk);
    #1;
    check("held.idle_after", busy1, 1'b0);

    check("sb.empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
